// File: rtl/cpu_pkg.sv
// Shared fetch-path constants and the fetch queue entry type.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// ROM read port, decode handshake and redirect bundle of the fetch stage.
interface instr_fetch_if #(
    parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
    parameter int unsigned INSTR_W = cpu_pkg::INSTR_W
);

    logic               o_rom_rd;
    logic [ADDR_W-1:0]  o_rom_raddr;
    logic [INSTR_W-1:0] i_rom_rdata;
    logic [INSTR_W-1:0] o_instr;
    logic [ADDR_W-1:0]  o_pc;
    logic               o_instr_valid;
    logic               i_dec_ready;
    logic               i_redirect;
    logic [ADDR_W-1:0]  i_redirect_pc;

    modport master (
        output o_rom_rd,
        output o_rom_raddr,
        input  i_rom_rdata,
        output o_instr,
        output o_pc,
        output o_instr_valid,
        input  i_dec_ready,
        input  i_redirect,
        input  i_redirect_pc
    );

    modport slave (
        input  o_rom_rd,
        input  o_rom_raddr,
        output i_rom_rdata,
        input  o_instr,
        input  o_pc,
        input  o_instr_valid,
        output i_dec_ready,
        output i_redirect,
        output i_redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO with registered head and flush.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter type T = fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       push_i,
    input  T           data_i,
    input  logic       pop_i,
    output T           data_o,
    output logic       valid_o,
    output logic [1:0] count_o
);

    T           mem_q [2];
    logic       rptr_q, rptr_d;
    logic       wptr_q, wptr_d;
    logic [1:0] count_q, count_d;
    logic       pop_ok, push_ok;

    assign pop_ok  = pop_i & (count_q != 2'd0);
    assign push_ok = push_i & ((count_q != 2'd2) | pop_ok);

    always_comb begin
        rptr_d  = rptr_q ^ pop_ok;
        wptr_d  = wptr_q ^ push_ok;
        count_d = count_q;
        unique case (1'b1)
            push_ok & ~pop_ok: count_d = count_q + 2'd1;
            pop_ok & ~push_ok: count_d = count_q - 2'd1;
            default:           count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rptr_q   <= 1'b0;
            wptr_q   <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rptr_q   <= 1'b0;
            wptr_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= data_i;
            end
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, ROM read issue, in-flight tracking and decode queue.
module instr_fetch #(
    parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned       INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input logic         clk,
    input logic         rst,
    instr_fetch_if.master bus
);

    import cpu_pkg::*;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] raddr;
    logic [2:0]        occ;
    logic              issue, push, pop;
    logic              head_valid;
    logic [1:0]        count;
    fetch_entry_t      head, entry;

    assign pop   = ~rst & head_valid & bus.i_dec_ready;
    assign occ   = {1'b0, count} + {2'b00, inflight_q};
    // occ >= pop always holds, since pop needs a non-empty queue
    assign issue = ~rst &
                   (bus.i_redirect | ((occ - {2'b00, pop}) < 3'd2));
    assign raddr = bus.i_redirect ? bus.i_redirect_pc : pc_q;
    assign push  = inflight_q & ~bus.i_redirect;

    assign pc_d      = issue ? raddr + ADDR_W'(1) : pc_q;
    assign infl_pc_d = issue ? raddr : infl_pc_q;

    always_comb begin
        entry       = '0;
        entry.instr = bus.i_rom_rdata;
        entry.pc    = infl_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            infl_pc_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            infl_pc_q  <= infl_pc_d;
            inflight_q <= issue;
        end
    end

    fetch_fifo #(
        .T (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.i_redirect),
        .push_i  (push),
        .data_i  (entry),
        .pop_i   (pop),
        .data_o  (head),
        .valid_o (head_valid),
        .count_o (count)
    );

    assign bus.o_rom_rd      = issue;
    assign bus.o_rom_raddr   = raddr;
    assign bus.o_instr_valid = ~rst & head_valid;
    assign bus.o_instr       = rst ? {INSTR_W{1'b0}} : head.instr;
    assign bus.o_pc          = rst ? {ADDR_W{1'b0}} : head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a stream-level reference model.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch #(
        .ADDR_W   (8),
        .INSTR_W  (16),
        .RESET_PC (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        return {a, ~a};
    endfunction

    logic [15:0] rom_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = rom_word(i[7:0]);
    end

    always @(posedge clk) begin
        if (bus.o_rom_rd) bus.i_rom_rdata <= rom_mem[bus.o_rom_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Stream model: the head, when valid, is always the next address
    // decode has not yet accepted since the last reset/redirect.
    logic [7:0] exp_pc;
    logic       pv, pr, predir, prst;
    logic [7:0] ppc;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", bus.o_instr_valid, 0);
            chk("rst_rd", bus.o_rom_rd, 0);
            chk("rst_instr", bus.o_instr, 0);
            chk("rst_pc", bus.o_pc, 0);
            exp_pc <= 8'h00;
        end else begin
            chk("no_x", $isunknown({bus.o_rom_rd, bus.o_rom_raddr,
                bus.o_instr, bus.o_pc, bus.o_instr_valid}), 0);
            if (pv && !pr && !predir && !prst)
                chk("stall_hold", {bus.o_instr_valid, bus.o_pc},
                    {1'b1, ppc});
            if (bus.o_instr_valid) begin
                chk("stream_pc", bus.o_pc, exp_pc);
                chk("stream_instr", bus.o_instr, rom_word(exp_pc));
            end
            if (bus.i_redirect)
                exp_pc <= bus.i_redirect_pc;
            else if (bus.o_instr_valid && bus.i_dec_ready)
                exp_pc <= exp_pc + 8'd1;
        end
        pv     <= bus.o_instr_valid;
        pr     <= bus.i_dec_ready;
        predir <= bus.i_redirect;
        prst   <= rst;
        ppc    <= bus.o_pc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic see(input string name, input logic v,
                       input logic [7:0] pc);
        chk({name, "_valid"}, bus.o_instr_valid, v);
        if (v) chk({name, "_pc"}, bus.o_pc, pc);
    endtask

    initial begin
        bus.i_dec_ready   = 1'b1;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 8'h00;
        rst = 1'b1;
        repeat (3) step();

        // startup latency and streaming
        rst = 1'b0;
        smp();
        chk("c0_rd", bus.o_rom_rd, 1);
        chk("c0_raddr", bus.o_rom_raddr, 8'h00);
        see("c0", 1'b0, 8'h00);
        step(); smp(); see("c1", 1'b0, 8'h00);
        step(); smp(); see("c2", 1'b1, 8'h00);
        chk("c2_instr", bus.o_instr, 16'h00FF);
        for (int k = 1; k <= 2; k++) begin
            step(); smp(); see("run", 1'b1, k[7:0]);
        end

        // backpressure at pc 3
        step(); bus.i_dec_ready = 1'b0; smp();
        see("stall0", 1'b1, 8'h03);
        chk("stall0_instr", bus.o_instr, 16'h03FC);
        chk("stall0_rd", bus.o_rom_rd, 0);
        repeat (4) begin
            step(); smp(); see("stall", 1'b1, 8'h03);
            chk("stall_rd", bus.o_rom_rd, 0);
        end
        step(); bus.i_dec_ready = 1'b1; smp();
        see("resume", 1'b1, 8'h03);
        chk("resume_rd", bus.o_rom_rd, 1);
        chk("resume_raddr", bus.o_rom_raddr, 8'h05);
        for (int k = 4; k <= 5; k++) begin
            step(); smp(); see("after", 1'b1, k[7:0]);
        end

        // redirect with pc 6 queued and pc 7 in flight
        step();
        bus.i_dec_ready   = 1'b0;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 8'h40;
        smp();
        see("redir", 1'b1, 8'h06);
        chk("redir_rd", bus.o_rom_rd, 1);
        chk("redir_raddr", bus.o_rom_raddr, 8'h40);
        step(); bus.i_redirect = 1'b0; bus.i_dec_ready = 1'b1; smp();
        see("redir1", 1'b0, 8'h00);
        step(); smp(); see("redir2", 1'b1, 8'h40);
        chk("redir2_instr", bus.o_instr, 16'h40BF);
        step(); smp(); see("redir3", 1'b1, 8'h41);
        step(); smp(); see("redir4", 1'b1, 8'h42);

        // redirect with pop, then back-to-back redirect
        step(); bus.i_redirect = 1'b1; bus.i_redirect_pc = 8'h10; smp();
        see("b2b0", 1'b1, 8'h43);
        step(); bus.i_redirect_pc = 8'h20; smp();
        see("b2b1", 1'b0, 8'h00);
        chk("b2b1_raddr", bus.o_rom_raddr, 8'h20);
        step(); bus.i_redirect = 1'b0; smp(); see("b2b2", 1'b0, 8'h00);
        step(); smp(); see("b2b3", 1'b1, 8'h20);
        chk("b2b3_instr", bus.o_instr, 16'h20DF);
        step(); smp(); see("b2b4", 1'b1, 8'h21);

        // PC wrap-around
        step(); bus.i_redirect = 1'b1; bus.i_redirect_pc = 8'hFE; smp();
        step(); bus.i_redirect = 1'b0; smp(); see("wrap1", 1'b0, 8'h00);
        step(); smp(); see("wrap2", 1'b1, 8'hFE);
        chk("wrap2_instr", bus.o_instr, 16'hFE01);
        step(); smp(); see("wrap3", 1'b1, 8'hFF);
        chk("wrap3_instr", bus.o_instr, 16'hFF00);
        step(); smp(); see("wrap4", 1'b1, 8'h00);
        step(); smp(); see("wrap5", 1'b1, 8'h01);

        // fill the queue, then reset mid-stream
        step(); bus.i_dec_ready = 1'b0; smp();
        step(); smp();
        step(); smp();
        see("full", 1'b1, 8'h02);
        chk("full_rd", bus.o_rom_rd, 0);
        step(); rst = 1'b1; smp();
        see("mrst", 1'b0, 8'h00);
        chk("mrst_rd", bus.o_rom_rd, 0);
        step(); rst = 1'b0; bus.i_dec_ready = 1'b1; smp();
        see("rel0", 1'b0, 8'h00);
        chk("rel0_rd", bus.o_rom_rd, 1);
        chk("rel0_raddr", bus.o_rom_raddr, 8'h00);
        step(); smp(); see("rel1", 1'b0, 8'h00);
        step(); smp(); see("rel2", 1'b1, 8'h00);
        chk("rel2_instr", bus.o_instr, 16'h00FF);
        step(); smp(); see("rel3", 1'b1, 8'h01);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
